mem_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single-port 8-bit system RAM between NUM_REQ requesters (CPU fetch/MOV path, stack engine, I/O DMA).
- Sits between the requesters and the RAM's address/data/write-enable pins.
- Captures one command per grant, runs a fixed 3-phase access (ACCESS, RESP, DONE), and returns read data with a one-cycle ack.
- Supports bounded locked bursts for a single requester.

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundle for the shared system-RAM arbiter. It carries two groups of signals:
//   * Requester side: req/we/lock/addr/wdata in (packed, requester i at slice i),
//     gnt/ack (one-hot), rdata and busy out.
//   * RAM side: mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in. The RAM is
//     synchronous, so read data arrives the cycle after mem_en.
// Modports:
//   slave  - the arbiter's view.
//   master - the requesters' and RAM model's view.
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic                      mem_en;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;

  modport slave (
    input  req, we, lock, addr, wdata, mem_rdata,
    output gnt, ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, lock, addr, wdata, mem_rdata,
    input  gnt, ack, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter and sequencer in front of the single-port system RAM.
// Each grant captures one command from the winning requester. The access then
// runs a fixed ACCESS -> RESP -> DONE sequence. The owner can keep the RAM for
// up to LOCK_MAX consecutive transfers by holding lock together with req.
// Ports:
//   clk   - system clock, all state changes on posedge
//   reset - asynchronous, active-low reset
//   bus   - mem_arbiter_if.slave (requester handshake plus RAM pins)
// All outputs come straight from registers, so there is no combinational path
// from the requester inputs to any output.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   last_q;
  logic [CNT_W-1:0]   lock_cnt_q;
  logic               cmd_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               mem_en_q;
  logic               mem_we_q;
  logic               busy_q;

  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic               relock;
  logic               grant;
  logic [IDX_W-1:0]   next_owner;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  // Round-robin scan. The search starts one past the last winner, so the most
  // recent owner is checked last.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_q) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_valid && bus.req[cand_idx]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // A locked re-grant is only possible straight out of DONE. Once the burst
  // cap is reached, the owner competes through the normal scan like everyone
  // else.
  assign relock     = (state_q == DONE) && bus.lock[owner_q] && bus.req[owner_q] &&
                      (lock_cnt_q < CNT_W'(LOCK_MAX));
  assign grant      = relock || win_valid;
  assign next_owner = relock ? owner_q : win_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      lock_cnt_q  <= '0;
      cmd_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE, DONE: begin
          if (grant) begin
            state_q     <= ACCESS;
            owner_q     <= next_owner;
            cmd_we_q    <= bus.we[next_owner];
            mem_addr_q  <= ADDR_W'(bus.addr >> (ADDR_W * int'(next_owner)));
            mem_wdata_q <= DATA_W'(bus.wdata >> (DATA_W * int'(next_owner)));
            gnt_q       <= onehot(next_owner);
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.we[next_owner];
            busy_q      <= 1'b1;
            if (relock) begin
              lock_cnt_q <= lock_cnt_q + 1'b1;
            end else begin
              lock_cnt_q <= CNT_W'(1);
              last_q     <= win_idx;
            end
          end else begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        ACCESS: begin
          state_q  <= RESP;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
        RESP: begin
          // The synchronous RAM presents read data during RESP. For writes,
          // rdata keeps whatever it last held.
          if (!cmd_we_q) rdata_q <= bus.mem_rdata;
          ack_q   <= onehot(owner_q);
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Drives mem_arbiter through directed scenarios, then through random traffic.
// A synchronous RAM model sits on the memory pins.
// The reference model is written per transaction:
//   * a phase counter, 0 = free and 1..3 = cycles since the grant;
//   * the round-robin and lock rules as integer arithmetic;
//   * a shadow copy of the RAM contents.
// Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int NUM_REQ  = 2;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int LOCK_MAX = 4;

  logic clk;
  logic reset;

  mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, with a backdoor port used for preloading.
  logic [7:0] ram [256];
  logic       bd_we;
  logic [7:0] bd_addr;
  logic [7:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_t, m_owner, m_last, m_streak;
  bit         m_we;
  logic [7:0] m_addr, m_wdata, m_rdata;
  logic [7:0] exp_ram [256];

  function automatic bit bit_at(input logic [NUM_REQ-1:0] v, input int i);
    return ((v >> i) & NUM_REQ'(1)) != 0;
  endfunction

  task automatic model_reset();
    m_t = 0; m_owner = 0; m_last = NUM_REQ - 1; m_streak = 0;
    m_we = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
  endtask

  task automatic model_take(input int who);
    m_owner = who;
    m_we    = bit_at(bus.we, who);
    m_addr  = 8'(bus.addr >> (who * 8));
    m_wdata = 8'(bus.wdata >> (who * 8));
    m_t     = 1;
  endtask

  // Advance one clock edge using the inputs currently applied.
  task automatic model_step();
    int w;
    if (m_t == 1) begin
      if (m_we) exp_ram[m_addr] = m_wdata;
      m_t = 2;
    end else if (m_t == 2) begin
      if (!m_we) m_rdata = exp_ram[m_addr];
      m_t = 3;
    end else if (m_t == 3 && bit_at(bus.lock, m_owner) && bit_at(bus.req, m_owner) &&
                 m_streak < LOCK_MAX) begin
      m_streak++;
      model_take(m_owner);
    end else begin
      w = -1;
      for (int k = 1; k <= NUM_REQ; k++)
        if (w < 0 && bit_at(bus.req, (m_last + k) % NUM_REQ)) w = (m_last + k) % NUM_REQ;
      if (w >= 0) begin
        m_last = w; m_streak = 1; model_take(w);
      end else begin
        m_t = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] own;
    own = 32'd1 << m_owner;
    check_val("gnt",       32'(bus.gnt),       (m_t != 0) ? own : 32'd0);
    check_val("ack",       32'(bus.ack),       (m_t == 3) ? own : 32'd0);
    check_val("busy",      32'(bus.busy),      (m_t != 0) ? 32'd1 : 32'd0);
    check_val("mem_en",    32'(bus.mem_en),    (m_t == 1) ? 32'd1 : 32'd0);
    check_val("mem_we",    32'(bus.mem_we),    (m_t == 1 && m_we) ? 32'd1 : 32'd0);
    check_val("mem_addr",  32'(bus.mem_addr),  32'(m_addr));
    check_val("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
    check_val("rdata",     32'(bus.rdata),     32'(m_rdata));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clear_inputs();
    bus.req = '0; bus.we = '0; bus.lock = '0; bus.addr = '0; bus.wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_outputs();
  endtask

  int acks[$];
  int lock_exp[9];

  initial begin
    reset = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    clear_inputs();
    model_reset();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      bd_we   = 1'b1;
      bd_addr = 8'(i);
      bd_data = (i == 32'h20) ? 8'hA5 : 8'($urandom);
      exp_ram[i] = bd_data;
    end
    @(negedge clk);
    bd_we = 1'b0;
    reset = 1'b1;
    check_outputs();

    // Idle stability.
    repeat (20) step();

    // Single read of 0x20 by requester 0.
    bus.req = 2'b01; bus.we = 2'b00; bus.addr = 16'h0020;
    step();
    check_val("rd_addr", 32'(bus.mem_addr), 32'h20);
    bus.req = 2'b00;
    step(); step();
    check_val("rd_ack",  32'(bus.ack),   32'h1);
    check_val("rd_data", 32'(bus.rdata), 32'hA5);
    step();
    check_val("rd_idle", 32'(bus.busy),  32'h0);

    // Write 0x3C to 0x7F, then read it back, both by requester 1.
    bus.req = 2'b10; bus.we = 2'b10; bus.addr = 16'h7F00; bus.wdata = 16'h3C00;
    step();
    check_val("wr_we",    32'(bus.mem_we),    32'h1);
    check_val("wr_wdata", 32'(bus.mem_wdata), 32'h3C);
    bus.we = 2'b00;
    step(); step();
    check_val("wr_ack",  32'(bus.ack),   32'h2);
    check_val("wr_hold", 32'(bus.rdata), 32'hA5);
    step();
    bus.req = 2'b00;
    step(); step();
    check_val("rb_ack",  32'(bus.ack),   32'h2);
    check_val("rb_data", 32'(bus.rdata), 32'h3C);
    step();

    // Round-robin fairness with both requesters held high.
    do_reset();
    bus.req = 2'b11; bus.addr = 16'h0504;
    acks.delete();
    repeat (12) begin
      step();
      if (bus.ack != 0) acks.push_back((bus.ack == 2'b10) ? 1 : 0);
    end
    check_val("rr_count", (acks.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 4 && i < acks.size(); i++)
      check_val($sformatf("rr_order%0d", i), 32'(acks[i]), 32'(i % 2));
    for (int i = 1; i < acks.size(); i++)
      check_val("rr_alt", (acks[i] != acks[i-1]) ? 32'd1 : 32'd0, 32'd1);

    // Lock cap: four to requester 0, one to requester 1, then four to 0 again.
    do_reset();
    bus.req = 2'b11; bus.lock = 2'b01; bus.addr = 16'h0908;
    lock_exp = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    acks.delete();
    repeat (27) begin
      step();
      if (bus.ack != 0) acks.push_back((bus.ack == 2'b10) ? 1 : 0);
    end
    check_val("lk_count", 32'(acks.size()), 32'd9);
    for (int i = 0; i < 9 && i < acks.size(); i++)
      check_val($sformatf("lk_order%0d", i), 32'(acks[i]), 32'(lock_exp[i]));

    // Reset asserted during the ACCESS cycle of a write.
    do_reset();
    bus.req = 2'b01; bus.we = 2'b01; bus.addr = 16'h0011; bus.wdata = 16'h00EE;
    step();
    #2 reset = 1'b0;
    #1;
    check_val("rst_mem_en", 32'(bus.mem_en), 32'h0);
    check_val("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check_val("rst_gnt",    32'(bus.gnt),    32'h0);
    check_val("rst_busy",   32'(bus.busy),   32'h0);
    model_reset();
    bus.req = 2'b11; bus.we = 2'b00; bus.lock = 2'b00;
    @(posedge clk);
    @(negedge clk);
    check_val("rst_ack", 32'(bus.ack), 32'h0);
    reset = 1'b1;
    step();
    check_val("rst_first", 32'(bus.gnt), 32'h1);
    bus.req = 2'b00;
    repeat (3) step();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      bus.req   = ($urandom_range(7) == 0) ? 2'b00 : 2'($urandom);
      bus.we    = 2'($urandom);
      bus.lock  = 2'($urandom);
      bus.addr  = {4'h0, 4'($urandom), 4'h0, 4'($urandom)};
      bus.wdata = 16'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
